log_scheduler: RTL and testbench

LOG_SCHEDULER -- requirements
Module: log_scheduler

---
 rtl/log_pkg.sv | 46 ++++
 rtl/log_wrap_step.sv | 32 +++
 rtl/log_scheduler.sv | 127 ++++++++++++
 tb/tb_log_scheduler.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/log_pkg.sv
// Shared constants, lane tables and FSM state type for the log scheduler.
package log_pkg;

  localparam int NUM_OF_LOGS   = 30;
  localparam int LOGS_PER_LANE = 6;
  localparam int SCREEN_W      = 640;
  localparam int NUM_LANES     = NUM_OF_LOGS / LOGS_PER_LANE;
  localparam int LANE_Y0       = 100;
  localparam int LANE_PITCH    = 32;
  localparam int LOG_SPACING   = 100;
  localparam int LANE_IDX_W    = 3;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_e;

  // Entry [0] is lane 0; direction bit 1 means the lane moves left.
  localparam logic [NUM_LANES-1:0][2:0] LANE_SPEED = {3'd2, 3'd3, 3'd1, 3'd2, 3'd1};
  localparam logic [NUM_LANES-1:0]      LANE_DIR   = 5'b01010;

  function automatic logic [2:0] lane_speed(input int lane);
    logic [2:0] s;
    s = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (l == lane) s = LANE_SPEED[LANE_IDX_W'(l)];
    end
    return s;
  endfunction

  function automatic dir_e lane_dir(input int lane);
    dir_e d;
    d = DIR_RIGHT;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (l == lane) d = LANE_DIR[LANE_IDX_W'(l)] ? DIR_LEFT : DIR_RIGHT;
    end
    return d;
  endfunction

endpackage

// File: rtl/log_wrap_step.sv
// One horizontal step of a log with wrap-around at the screen edge.
module log_wrap_step #(
  parameter int SCREEN_W = log_pkg::SCREEN_W
) (
  input  logic [10:0]       x_i,
  input  logic [2:0]        speed_i,
  input  log_pkg::dir_e     dir_i,
  output logic [10:0]       x_o
);
  import log_pkg::*;

  logic [11:0] x_wide;
  logic [11:0] s_wide;
  logic [11:0] sum;
  logic [11:0] x_next;

  assign x_wide = {1'b0, x_i};
  assign s_wide = {9'b0, speed_i};
  assign sum    = x_wide + s_wide;

  always_comb begin
    x_next = x_wide;
    if (dir_i == DIR_RIGHT) begin
      x_next = (sum >= 12'(SCREEN_W)) ? sum - 12'(SCREEN_W) : sum;
    end else begin
      x_next = (x_wide >= s_wide) ? x_wide - s_wide : x_wide + 12'(SCREEN_W) - s_wide;
    end
  end

  assign x_o = 11'(x_next);

endmodule

// File: rtl/log_scheduler.sv
// Walks every log once per startOfFrame, stepping one log per cycle.
// Optional LOG_SPEEDUP_EN adds a 2-bit level port that boosts every lane's speed.
module log_scheduler #(
  parameter int NUM_OF_LOGS   = log_pkg::NUM_OF_LOGS,
  parameter int LOGS_PER_LANE = log_pkg::LOGS_PER_LANE,
  parameter int SCREEN_W      = log_pkg::SCREEN_W
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        startOfFrame,
  input  logic        restart,
`ifdef LOG_SPEEDUP_EN
  input  logic [1:0]  level,
`endif
  output logic [10:0] ObjectStartX [NUM_OF_LOGS],
  output logic [10:0] ObjectStartY [NUM_OF_LOGS],
  output logic        busy,
  output logic        done,
  output logic        overrun
);
  import log_pkg::*;

  localparam int                IDX_W    = $clog2(NUM_OF_LOGS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_OF_LOGS - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              done_q, done_d;
  logic              overrun_q, overrun_d;
  logic [10:0]       x_q [NUM_OF_LOGS];

  logic [10:0]       cur_x, new_x;
  logic [2:0]        speed;
  dir_e              dir;
  int                lane_cur;
  logic              update_en;

  function automatic logic [10:0] init_x(input int i);
    return 11'((i % LOGS_PER_LANE) * LOG_SPACING);
  endfunction

  assign lane_cur = int'(idx_q) / LOGS_PER_LANE;
  assign cur_x    = x_q[idx_q];
  assign dir      = lane_dir(lane_cur);

`ifdef LOG_SPEEDUP_EN
  assign speed = lane_speed(lane_cur) + 3'(level);
`else
  assign speed = lane_speed(lane_cur);
`endif

  log_wrap_step #(
    .SCREEN_W (SCREEN_W)
  ) u_wrap_step (
    .x_i     (cur_x),
    .speed_i (speed),
    .dir_i   (dir),
    .x_o     (new_x)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = (state_q == DONE);
    overrun_d = overrun_q | (startOfFrame & (state_q != IDLE));
    case (state_q)
      IDLE: begin
        if (startOfFrame) begin
          state_d = UPDATE;
          idx_d   = '0;
        end
      end
      UPDATE: begin
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // restart outranks any frame request arriving in the same cycle
    if (restart) begin
      state_d   = IDLE;
      idx_d     = '0;
      done_d    = 1'b0;
      overrun_d = 1'b0;
    end
  end

  assign update_en = (state_q == UPDATE) && !restart;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || restart) begin
      for (int i = 0; i < NUM_OF_LOGS; i++) x_q[i] <= init_x(i);
    end else if (update_en) begin
      x_q[idx_q] <= new_x;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_OF_LOGS; gi++) begin : g_obj
      assign ObjectStartX[gi] = x_q[gi];
      assign ObjectStartY[gi] = 11'(LANE_Y0 + (gi / LOGS_PER_LANE) * LANE_PITCH);
    end
  endgenerate

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_log_scheduler.sv
// Randomised and directed bench for log_scheduler against a pass-level reference model.
module tb_log_scheduler;

  localparam int N   = 30;
  localparam int LPL = 6;
  localparam int W   = 640;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        startOfFrame = 1'b0;
  logic        restart = 1'b0;
`ifdef LOG_SPEEDUP_EN
  logic [1:0]  level_drv = 2'd0;
`endif
  logic [10:0] obj_x [N];
  logic [10:0] obj_y [N];
  logic        busy, done, overrun;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: positions plus "edges since the pass was accepted".
  int mx [N];
  bit m_active = 1'b0;
  int m_age = 0;
  bit m_done = 1'b0;
  bit m_ovr = 1'b0;
  int pass_cnt = 0;
  bit chk_en = 1'b0;
  int speeds [5] = '{1, 2, 1, 3, 2};

  log_scheduler dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .startOfFrame (startOfFrame),
    .restart      (restart),
`ifdef LOG_SPEEDUP_EN
    .level        (level_drv),
`endif
    .ObjectStartX (obj_x),
    .ObjectStartY (obj_y),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 CLK = ~CLK;

  function automatic int init_x(int i);
    return (i % LPL) * 100;
  endfunction

  function automatic int exp_y(int i);
    return 100 + (i / LPL) * 32;
  endfunction

  function automatic int mwrap(int x, int lane, int lvl);
    int s;
    s = speeds[lane] + lvl;
    if (lane % 2 == 0) return (x + s) % W;
    return (x - s + W) % W;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(input bit rst, input bit sof, input bit rs, input int lvl);
    if (rst || rs) begin
      for (int i = 0; i < N; i++) mx[i] = init_x(i);
      m_active = 1'b0;
      m_age    = 0;
      m_done   = 1'b0;
      m_ovr    = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_active) begin
        if (sof) m_ovr = 1'b1;
        m_age++;
        if (m_age >= 1 && m_age <= N) mx[m_age-1] = mwrap(mx[m_age-1], (m_age-1) / LPL, lvl);
        if (m_age == N + 1) begin
          m_active = 1'b0;
          m_done   = 1'b1;
          pass_cnt++;
        end
      end else if (sof) begin
        m_active = 1'b1;
        m_age    = 0;
      end
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input bit rst, input bit sof, input bit rs, input int lvl);
    RESET        = rst;
    startOfFrame = sof;
    restart      = rs;
`ifdef LOG_SPEEDUP_EN
    level_drv    = 2'(lvl);
`endif
    @(posedge CLK);
    model_edge(rst, sof, rs, lvl);
    @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (chk_en) begin
      int bad;
      bad = -1;
      for (int i = 0; i < N; i++) if (bad < 0 && obj_x[i] !== 11'(mx[i])) bad = i;
      n_cmp++;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL xpos: log %0d got %0d, expected %0d", bad, obj_x[bad], mx[bad]);
      end
      bad = -1;
      for (int i = 0; i < N; i++) if (bad < 0 && obj_y[i] !== 11'(exp_y(i))) bad = i;
      n_cmp++;
      if (bad >= 0) begin
        n_err++;
        $display("FAIL ypos: log %0d got %0d, expected %0d", bad, obj_y[bad], exp_y(bad));
      end
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(m_done));
      chk("overrun", 32'(overrun), 32'(m_ovr));
      if (m_done) $display("pass %0d complete, x0=%0d x29=%0d", pass_cnt, mx[0], mx[N-1]);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of run");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    int done_cnt;
    @(negedge CLK);
    step(1, 0, 0, 0);
    chk_en = 1'b1;
    step(1, 0, 0, 0);

    // reset state, then idle
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) chk($sformatf("reset_x%0d", i), 32'(obj_x[i]), 32'(i * 100));
    chk("reset_y6", 32'(obj_y[6]), 32'd132);
    chk("reset_busy", 32'(busy), 32'd0);

    // single pass timing
    busy_cnt = 0;
    step(0, 1, 0, 0);
    if (busy) busy_cnt++;
    for (int k = 1; k <= 31; k++) begin
      step(0, 0, 0, 0);
      if (busy) busy_cnt++;
      if (k == 1)  chk("pass1_x0", 32'(obj_x[0]), 32'd1);
      if (k == 7)  chk("pass1_x6", 32'(obj_x[6]), 32'd638);
      if (k == 30) chk("pass1_done_early", 32'(done), 32'd0);
      if (k == 31) begin
        chk("pass1_done", 32'(done), 32'd1);
        chk("pass1_busy_end", 32'(busy), 32'd0);
      end
    end
    chk("pass1_busy_cycles", 32'(busy_cnt), 32'd31);

    // 140 passes: lane 0 wraps 639 -> 0
    step(0, 0, 1, 0);
    for (int p = 1; p <= 140; p++) begin
      step(0, 1, 0, 0);
      for (int k = 0; k < 31; k++) step(0, 0, 0, 0);
      if (p == 139) chk("wrap_x5_p139", 32'(obj_x[5]), 32'd639);
    end
    chk("wrap_x5_p140", 32'(obj_x[5]), 32'd0);
    chk("wrap_x0_p140", 32'(obj_x[0]), 32'd140);
    chk("wrap_x6_p140", 32'(obj_x[6]), 32'd360);

    // frame request during a pass
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int k = 1; k <= 31; k++) begin
      step(0, (k == 10), 0, 0);
      if (k == 10) chk("ovr_set", 32'(overrun), 32'd1);
      if (k == 31) chk("ovr_done_time", 32'(done), 32'd1);
    end
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0);
    chk("ovr_sticky", 32'(overrun), 32'd1);
    step(0, 0, 1, 0);
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // restart together with a frame request mid-pass
    step(0, 1, 0, 0);
    for (int k = 1; k <= 14; k++) step(0, (k == 5), 0, 0);
    step(0, 1, 1, 0);
    chk("rs_busy", 32'(busy), 32'd0);
    chk("rs_x0", 32'(obj_x[0]), 32'd0);
    chk("rs_x7", 32'(obj_x[7]), 32'd100);
    chk("rs_ovr", 32'(overrun), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 35; k++) begin
      step(0, 0, 0, 0);
      if (done) done_cnt++;
    end
    chk("rs_no_done", 32'(done_cnt), 32'd0);

    // restart while in the completion state suppresses done
    step(0, 1, 0, 0);
    for (int k = 1; k <= 30; k++) step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("rs_in_done", 32'(done), 32'd0);

    // RESET mid-pass reverts partially updated logs
    step(0, 1, 0, 0);
    for (int k = 1; k <= 10; k++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_mid_x0", 32'(obj_x[0]), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    step(0, 0, 0, 0);

`ifdef LOG_SPEEDUP_EN
    step(0, 0, 1, 3);
    step(0, 1, 0, 3);
    for (int k = 1; k <= 31; k++) step(0, 0, 0, 3);
    chk("speedup_x18", 32'(obj_x[18]), 32'd634);
`endif

    // randomised traffic
    for (int c = 0; c < 3000; c++) begin
      bit r_sof, r_rs, r_rst;
      int r_lvl;
      r_sof = ($urandom_range(15) == 0);
      r_rs  = ($urandom_range(199) == 0);
      r_rst = ($urandom_range(499) == 0);
`ifdef LOG_SPEEDUP_EN
      r_lvl = int'($urandom_range(3));
`else
      r_lvl = 0;
`endif
      step(r_rst, r_sof, r_rs, r_lvl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
